sa_ram_rws_gen: RTL and testbench

Parametrised single-clock 1R1W synchronous RAM model for FPGA builds of the systolic-array buffers, replacing the fixed-geometry `rws` models. It adds the following over those models:
- byte-enable writes;
- a selectable read-during-write policy;
- a registered, hold-stable read output with configurable read latency of 1 or 2;
- a read-valid strobe;
- a power-down gate.

It sits between the SA tile controllers and their operand/result buffers.

---
 rtl/sa_ram_pkg.sv | 32 +++
 rtl/sa_ram_rws_gen_if.sv | 33 +++
 rtl/sa_ram_rd_pipe.sv | 71 +++++++
 rtl/sa_ram_rws_gen.sv | 88 ++++++++
 tb/tb_sa_ram_rws_gen.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sa_ram_pkg.sv
`default_nettype none
// ============================================================================
// Package : sa_ram_pkg
// Desc    : Constants and byte-merge helper shared by the SA RAM generators.
// Rev     : 1.0
// ============================================================================
package sa_ram_pkg;

    localparam int RD_LAT_1   = 1;
    localparam int RD_LAT_2   = 2;
    localparam int BYPASS_NEW = 1;
    localparam int BYPASS_OLD = 0;

    // Widest word any generator may request; callers cast to and from this width.
    localparam int c_MAX_WIDTH = 4096;
    localparam int c_MAX_BE    = c_MAX_WIDTH / 8;

    function automatic logic [c_MAX_WIDTH-1:0] byte_merge(
        input logic [c_MAX_WIDTH-1:0] old_w,
        input logic [c_MAX_WIDTH-1:0] new_w,
        input logic [c_MAX_BE-1:0]    be
    );
        logic [c_MAX_WIDTH-1:0] m;
        m = old_w;
        for (int i = 0; i < c_MAX_BE; i++) begin
            if (be[i]) m[8*i +: 8] = new_w[8*i +: 8];
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sa_ram_rws_gen_if.sv
`default_nettype none
// ============================================================================
// Interface : sa_ram_rws_gen_if
// Desc      : Read/write/power-down bus between an SA tile controller and RAM.
// Rev       : 1.0
// ============================================================================
interface sa_ram_rws_gen_if #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 512,
    parameter int AW    = $clog2(DEPTH)
);
    logic [AW-1:0]      ra;
    logic               re;
    logic [WIDTH-1:0]   dout;
    logic               dout_vld;
    logic [AW-1:0]      wa;
    logic               we;
    logic [WIDTH/8-1:0] wbe;
    logic [WIDTH-1:0]   di;
    logic [31:0]        pwrbus_ram_pd;
    logic               rd_collide;

    modport master (
        output ra, re, wa, we, wbe, di, pwrbus_ram_pd,
        input  dout, dout_vld, rd_collide
    );

    modport slave (
        input  ra, re, wa, we, wbe, di, pwrbus_ram_pd,
        output dout, dout_vld, rd_collide
    );
endinterface
`default_nettype wire

// File: rtl/sa_ram_rd_pipe.sv
`default_nettype none
// ============================================================================
// Module : sa_ram_rd_pipe
// Desc   : 1- or 2-stage read output pipeline (valid, data, collide flag).
// Rev    : 1.0
// ============================================================================
module sa_ram_rd_pipe
    import sa_ram_pkg::*;
#(
    parameter int WIDTH  = 512,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_vld,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_col,
    output logic             o_vld,
    output logic [WIDTH-1:0] o_data,
    output logic             o_col
);

    logic             r_vld1;
    logic [WIDTH-1:0] r_data1;
    logic             r_col1;

    // Data and collide flag load only on a valid read so the output holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld1  <= 1'b0;
            r_data1 <= '0;
            r_col1  <= 1'b0;
        end else begin
            r_vld1 <= i_vld;
            if (i_vld) begin
                r_data1 <= i_data;
                r_col1  <= i_col;
            end
        end
    end

    if (RD_LAT == RD_LAT_2) begin : g_lat2
        logic             r_vld2;
        logic [WIDTH-1:0] r_data2;
        logic             r_col2;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_vld2  <= 1'b0;
                r_data2 <= '0;
                r_col2  <= 1'b0;
            end else begin
                r_vld2 <= r_vld1;
                if (r_vld1) begin
                    r_data2 <= r_data1;
                    r_col2  <= r_col1;
                end
            end
        end

        assign o_vld  = r_vld2;
        assign o_data = r_data2;
        assign o_col  = r_col2;
    end else begin : g_lat1
        assign o_vld  = r_vld1;
        assign o_data = r_data1;
        assign o_col  = r_col1;
    end

endmodule
`default_nettype wire

// File: rtl/sa_ram_rws_gen.sv
`default_nettype none
// ============================================================================
// Module : sa_ram_rws_gen
// Desc   : Parametrised 1R1W RAM with byte enables, RDW policy and power-down.
// Rev    : 1.0
// ============================================================================
module sa_ram_rws_gen
    import sa_ram_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int WIDTH  = 512,
    parameter int AW     = $clog2(DEPTH),
    parameter int RD_LAT = 1,
    parameter int BYPASS = 1
) (
    input  logic            clk,
    input  logic            rst,
    sa_ram_rws_gen_if.slave bus
);

    localparam int          c_WB    = WIDTH / 8;
    localparam logic [AW:0] c_DEPTH = (AW+1)'(DEPTH);

    if (!(RD_LAT == RD_LAT_1 || RD_LAT == RD_LAT_2)) begin : g_chk_lat
        $error("sa_ram_rws_gen: RD_LAT must be 1 or 2");
    end
    if (WIDTH % 8 != 0) begin : g_chk_width
        $error("sa_ram_rws_gen: WIDTH must be a multiple of 8");
    end
    if (WIDTH > c_MAX_WIDTH) begin : g_chk_max_width
        $error("sa_ram_rws_gen: WIDTH exceeds byte_merge capacity");
    end
    if (DEPTH < 2) begin : g_chk_depth
        $error("sa_ram_rws_gen: DEPTH must be at least 2");
    end

    logic [WIDTH-1:0] r_mem [DEPTH];

    logic             w_acc;
    logic             w_we_q;
    logic             w_re_q;
    logic             w_wa_ok;
    logic             w_ra_ok;
    logic             w_collide;
    logic [WIDTH-1:0] w_rd_old;
    logic [WIDTH-1:0] w_rd_word;

    assign w_acc     = !rst && !(|bus.pwrbus_ram_pd);
    assign w_we_q    = bus.we && w_acc;
    assign w_re_q    = bus.re && w_acc;
    assign w_wa_ok   = {1'b0, bus.wa} < c_DEPTH;
    assign w_ra_ok   = {1'b0, bus.ra} < c_DEPTH;
    assign w_collide = w_re_q && w_we_q && w_ra_ok && (bus.ra == bus.wa);
    assign w_rd_old  = w_ra_ok ? r_mem[bus.ra] : '0;

    // Per-byte write keeps FPGA byte-enable RAM inference intact.
    always_ff @(posedge clk) begin
        if (w_we_q && w_wa_ok) begin
            for (int i = 0; i < c_WB; i++) begin
                if (bus.wbe[i]) r_mem[bus.wa][8*i +: 8] <= bus.di[8*i +: 8];
            end
        end
    end

    if (BYPASS == BYPASS_NEW) begin : g_bypass_new
        assign w_rd_word = w_collide
            ? WIDTH'(byte_merge(c_MAX_WIDTH'(w_rd_old), c_MAX_WIDTH'(bus.di), c_MAX_BE'(bus.wbe)))
            : w_rd_old;
    end else begin : g_bypass_old
        assign w_rd_word = w_rd_old;
    end

    sa_ram_rd_pipe #(
        .WIDTH  (WIDTH),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk    (clk),
        .rst    (rst),
        .i_vld  (w_re_q),
        .i_data (w_rd_word),
        .i_col  (w_collide),
        .o_vld  (bus.dout_vld),
        .o_data (bus.dout),
        .o_col  (bus.rd_collide)
    );

endmodule
`default_nettype wire

// File: tb/tb_sa_ram_rws_gen.sv
`default_nettype none
// ============================================================================
// Module : tb_sa_ram_rws_gen
// Desc   : Scoreboard bench driving four RAM configurations with one stream.
// Rev    : 1.0
// ============================================================================
module tb_sa_ram_rws_gen;
    import sa_ram_pkg::*;

    localparam int W  = 512;
    localparam int WB = W / 8;
    localparam int AW = 6;
    localparam int NP = 4;

    // Port configs: 0 = LAT1/new, 1 = LAT1/old, 2 = LAT2/new, 3 = DEPTH 48 LAT1/new
    function automatic int depth_of(input int p); return (p == 3) ? 48 : 64; endfunction
    function automatic int lat_of(input int p);   return (p == 2) ? 2 : 1;   endfunction
    function automatic bit byp_of(input int p);   return (p != 1);           endfunction

    logic          clk = 1'b0;
    logic          rst;
    logic          re, we;
    logic [AW-1:0] ra, wa;
    logic [WB-1:0] wbe;
    logic [W-1:0]  di;
    logic [31:0]   pd;

    always #5 clk = ~clk;

    sa_ram_rws_gen_if #(.DEPTH(64), .WIDTH(W)) bus0 ();
    sa_ram_rws_gen_if #(.DEPTH(64), .WIDTH(W)) bus1 ();
    sa_ram_rws_gen_if #(.DEPTH(64), .WIDTH(W)) bus2 ();
    sa_ram_rws_gen_if #(.DEPTH(48), .WIDTH(W)) bus3 ();

    assign bus0.ra = ra, bus0.re = re, bus0.wa = wa, bus0.we = we, bus0.wbe = wbe, bus0.di = di, bus0.pwrbus_ram_pd = pd;
    assign bus1.ra = ra, bus1.re = re, bus1.wa = wa, bus1.we = we, bus1.wbe = wbe, bus1.di = di, bus1.pwrbus_ram_pd = pd;
    assign bus2.ra = ra, bus2.re = re, bus2.wa = wa, bus2.we = we, bus2.wbe = wbe, bus2.di = di, bus2.pwrbus_ram_pd = pd;
    assign bus3.ra = ra, bus3.re = re, bus3.wa = wa, bus3.we = we, bus3.wbe = wbe, bus3.di = di, bus3.pwrbus_ram_pd = pd;

    sa_ram_rws_gen #(.DEPTH(64), .WIDTH(W), .RD_LAT(RD_LAT_1), .BYPASS(BYPASS_NEW))
        u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
    sa_ram_rws_gen #(.DEPTH(64), .WIDTH(W), .RD_LAT(RD_LAT_1), .BYPASS(BYPASS_OLD))
        u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
    sa_ram_rws_gen #(.DEPTH(64), .WIDTH(W), .RD_LAT(RD_LAT_2), .BYPASS(BYPASS_NEW))
        u_dut2 (.clk(clk), .rst(rst), .bus(bus2));
    sa_ram_rws_gen #(.DEPTH(48), .WIDTH(W), .RD_LAT(RD_LAT_1), .BYPASS(BYPASS_NEW))
        u_dut3 (.clk(clk), .rst(rst), .bus(bus3));

    logic [W-1:0] dout_a [NP];
    logic         vld_a  [NP];
    logic         col_a  [NP];
    assign dout_a[0] = bus0.dout, vld_a[0] = bus0.dout_vld, col_a[0] = bus0.rd_collide;
    assign dout_a[1] = bus1.dout, vld_a[1] = bus1.dout_vld, col_a[1] = bus1.rd_collide;
    assign dout_a[2] = bus2.dout, vld_a[2] = bus2.dout_vld, col_a[2] = bus2.rd_collide;
    assign dout_a[3] = bus3.dout, vld_a[3] = bus3.dout_vld, col_a[3] = bus3.rd_collide;

    typedef struct {
        int           port;
        logic [W-1:0] data;
        logic         col;
        int           due;
    } exp_t;

    exp_t         sb [$];
    logic [W-1:0] mdl    [NP][64];
    logic [W-1:0] hold_d [NP];
    logic         hold_c [NP];
    int           cyc = 0;
    logic         rst_q = 1'b0;
    logic         started = 1'b0;
    int           n_checks = 0;
    int           n_errors = 0;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rst_q   <= rst;
        if (rst) started <= 1'b1;
    end

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] apply_be(input logic [W-1:0] o, input logic [W-1:0] n, input logic [WB-1:0] be);
        logic [W-1:0] r;
        for (int b = 0; b < WB; b++) r[8*b +: 8] = be[b] ? n[8*b +: 8] : o[8*b +: 8];
        return r;
    endfunction

    function automatic logic [W-1:0] rep(input logic [7:0] b);
        return {WB{b}};
    endfunction

    function automatic logic [W-1:0] rnd();
        logic [W-1:0] r;
        for (int k = 0; k < W/32; k++) r[32*k +: 32] = $urandom;
        return r;
    endfunction

    // Model the edge about to happen, then advance to the following falling edge.
    task automatic step();
        logic acc;
        acc = !rst && (pd == 32'd0);
        if (rst) begin
            for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].due > cyc) sb.delete(i);
        end
        for (int p = 0; p < NP; p++) begin
            if (acc && re) begin
                exp_t e;
                e.port = p;
                e.due  = cyc + lat_of(p);
                if (int'(ra) < depth_of(p)) begin
                    e.col  = we && (wa == ra);
                    e.data = (e.col && byp_of(p)) ? apply_be(mdl[p][ra], di, wbe) : mdl[p][ra];
                end else begin
                    e.col  = 1'b0;
                    e.data = '0;
                end
                sb.push_back(e);
            end
            if (acc && we && int'(wa) < depth_of(p)) mdl[p][wa] = apply_be(mdl[p][wa], di, wbe);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic r_en, input int raddr, input logic w_en, input int waddr,
                         input logic [WB-1:0] be, input logic [W-1:0] d);
        re  = r_en;
        ra  = AW'(raddr);
        we  = w_en;
        wa  = AW'(waddr);
        wbe = be;
        di  = d;
        step();
    endtask

    always @(negedge clk) begin
        if (started) begin
            for (int p = 0; p < NP; p++) begin
                int   idx;
                logic ev;
                idx = -1;
                for (int i = 0; i < sb.size(); i++) begin
                    if (sb[i].port == p) begin
                        idx = i;
                        break;
                    end
                end
                if (idx >= 0 && sb[idx].due < cyc) begin
                    check($sformatf("p%0d missed_read", p), W'(0), W'(1));
                    sb.delete(idx);
                    idx = -1;
                end
                ev = (idx >= 0) && (sb[idx].due == cyc);
                check($sformatf("p%0d dout_vld c%0d", p, cyc), W'(vld_a[p]), W'(ev));
                if (rst_q) begin
                    hold_d[p] = '0;
                    hold_c[p] = 1'b0;
                end else if (ev) begin
                    hold_d[p] = sb[idx].data;
                    hold_c[p] = sb[idx].col;
                    sb.delete(idx);
                end
                check($sformatf("p%0d dout c%0d", p, cyc), dout_a[p], hold_d[p]);
                check($sformatf("p%0d rd_collide c%0d", p, cyc), W'(col_a[p]), W'(hold_c[p]));
            end
        end
    end

    initial begin
        int r_a, w_a;
        rst = 1'b1; pd = '0; re = 1'b1; ra = AW'(5); we = 1'b0; wa = '0; wbe = '0; di = '0;
        repeat (3) step();
        rst = 1'b0;

        // Write/read and hold across later writes to the same address
        drive(1'b0, 0, 1'b1, 5, '1, rep(8'hA5));
        drive(1'b1, 5, 1'b0, 0, '0, '0);
        repeat (10) drive(1'b0, 0, 1'b1, 5, '1, '0);

        // Partial byte-enable write
        drive(1'b0, 0, 1'b1, 3, '1, rep(8'h11));
        drive(1'b0, 0, 1'b1, 3, WB'(64'hF), rep(8'hFF));
        drive(1'b1, 3, 1'b0, 0, '0, '0);

        // Same-address read during write, then a plain follow-up read
        drive(1'b0, 0, 1'b1, 7, '1, rep(8'h22));
        drive(1'b1, 7, 1'b1, 7, WB'(64'h0000_0000_FFFF_FFFF), rep(8'h99));
        drive(1'b1, 7, 1'b0, 0, '0, '0);
        drive(1'b0, 0, 1'b0, 0, '0, '0);

        // Preload, then stream reads back-to-back
        for (int a = 0; a < 16; a++) drive(1'b0, 0, 1'b1, a, '1, rnd());
        for (int a = 0; a < 8; a++) drive(1'b1, a, 1'b0, 0, '0, '0);
        repeat (3) drive(1'b0, 0, 1'b0, 0, '0, '0);

        // Streaming interrupted by reset on the fourth cycle
        for (int a = 0; a < 4; a++) begin
            rst = (a == 3);
            drive(1'b1, a, 1'b0, 0, '0, '0);
        end
        rst = 1'b0;
        repeat (3) drive(1'b0, 0, 1'b0, 0, '0, '0);

        // Address range: 50 is beyond DEPTH 48, 47 is its last word
        drive(1'b0, 0, 1'b1, 47, '1, rnd());
        drive(1'b0, 0, 1'b1, 50, '1, rnd());
        drive(1'b1, 50, 1'b0, 0, '0, '0);
        drive(1'b1, 47, 1'b0, 0, '0, '0);

        // Power-down gating; the read just before pd rises must complete
        drive(1'b1, 1, 1'b0, 0, '0, '0);
        pd = 32'h1;
        repeat (4) drive(1'b1, 2, 1'b1, 2, '1, rnd());
        pd = '0;
        drive(1'b1, 2, 1'b0, 0, '0, '0);
        drive(1'b0, 0, 1'b0, 0, '0, '0);

        // Mixed random traffic with frequent collisions and sporadic power-down
        for (int n = 0; n < 60; n++) begin
            r_a = ($urandom_range(0, 7) == 0) ? 50 : int'($urandom_range(0, 15));
            w_a = ($urandom_range(0, 2) == 0) ? r_a : int'($urandom_range(0, 15));
            pd  = ($urandom_range(0, 9) == 0) ? 32'h8000_0000 : 32'h0;
            drive(1'($urandom_range(0, 1)), r_a, 1'($urandom_range(0, 1)), w_a,
                  {$urandom, $urandom}, rnd());
        end
        pd = '0;
        repeat (4) drive(1'b0, 0, 1'b0, 0, '0, '0);

        check("scoreboard_drain", W'(sb.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
